// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - BCD round countdown timer with idle/run/pause/expired sequencing
module round_timer_ctrl #(
    parameter int TICKS_PER_SEC = 10,
    parameter int WARN_SECS     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_100ms,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       running,
    output logic       warn,
    output logic       time_up,
    output logic       expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TICKS_PER_SEC - 1);
    localparam logic [3:0] WARN_MAX = 4'(WARN_SECS);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] cnt_q, cnt_d;
    logic       time_up_q, time_up_d;
    logic       expiring;

    // Non-BCD preset digits saturate at 9 rather than wrapping
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Next-state: tick accounting in RUN, request handling elsewhere
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        cnt_d     = cnt_q;
        time_up_d = 1'b0;
        expiring  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // The tick is applied before stop so an expiring tick wins over a pause
                if (tick_100ms) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = 8'd0;
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                        if (tens_q == 4'd0 && ones_q == 4'd1) begin
                            expiring  = 1'b1;
                            state_d   = ST_EXPIRED;
                            time_up_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                if (stop && !expiring) begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                // IDLE, PAUSE and EXPIRED: load dominates; stop is a no-op that still blocks start
                if (load) begin
                    tens_d  = clamp_bcd(preset_tens);
                    ones_d  = clamp_bcd(preset_ones);
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (start && !stop && state_q != ST_EXPIRED &&
                             (tens_q != 4'd0 || ones_q != 4'd0)) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            cnt_q     <= 8'd0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            cnt_q     <= cnt_d;
            time_up_q <= time_up_d;
        end
    end

    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign state    = state_q;
    assign running  = (state_q == ST_RUN);
    assign expired  = (state_q == ST_EXPIRED);
    assign time_up  = time_up_q;
    assign warn     = running && (tens_q == 4'd0) && (ones_q != 4'd0) && (ones_q <= WARN_MAX);

endmodule

// File: doc/round_timer_ctrl.md
Name: round_timer_ctrl

Overview:
Game round countdown controller for the BCD math game.
- Consumes the 100 ms timebase pulse and counts a preset time in two BCD digits (00-99 s) down to zero.
- Sequences the round through idle/run/pause/expired.
- Drives the seconds display digits, a low-time warning, and a single-cycle time-up event to the game FSM.

Parameters:
TICKS_PER_SEC, 10, number of tick_100ms pulses per decremented second (legal 2-255)
WARN_SECS, 5, warn asserts while running with remaining time 01..WARN_SECS seconds (legal 0-9; 0 disables warn)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
tick_100ms  input  1  single-cycle timebase pulse, one per 100 ms
load  input  1  single-cycle request: capture preset digits
preset_tens  input  4  BCD tens digit of round time
preset_ones  input  4  BCD ones digit of round time
start  input  1  single-cycle request: start or resume countdown
stop  input  1  single-cycle request: pause countdown
sec_tens  output  4  remaining seconds, BCD tens
sec_ones  output  4  remaining seconds, BCD ones
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 EXPIRED
running  output  1  high while state==RUN
warn  output  1  low-time warning level
time_up  output  1  one-cycle pulse on expiry
expired  output  1  high while state==EXPIRED

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, sec_tens=0, sec_ones=0, internal tick counter=0, running=0, warn=0, time_up=0, expired=0. Release is sampled synchronously; the first active edge is the one after reset goes high.
- All outputs are registers or decodes of registers. No combinational path from inputs to outputs.
- load, accepted in IDLE, PAUSE and EXPIRED:
  - Captures preset digits; any digit >9 is clamped to 9.
  - Clears the tick counter; next state is IDLE.
  - Ignored in RUN.
- start:
  - IDLE or PAUSE with time !=00 -> RUN. The tick counter is retained, so resume continues the partial second.
  - Ignored with time ==00, in RUN, and in EXPIRED.
- stop: RUN -> PAUSE; ignored elsewhere.
- Same-cycle priority:
  - load > stop > start.
  - start+stop in IDLE or PAUSE: no transition.
- Ticks:
  - Counted only in RUN; ignored in all other states.
  - On each tick the counter increments. On the tick where counter==TICKS_PER_SEC-1, the counter wraps to 0 and the BCD time decrements by one.
  - BCD decrement: ones>0 -> ones-1; ones==0 -> ones=9, tens-1. Tens never underflows because 00 is never decremented.
- Expiry: on the edge where the decrement produces 00:
  - State becomes EXPIRED and time_up=1 for exactly that following cycle.
  - expired=1 until the next load.
- stop and the expiring tick in the same cycle: the tick is applied first and expiry wins (EXPIRED, time_up pulses). A non-expiring tick plus stop is counted, then the block enters PAUSE.
- warn = running AND tens==0 AND 1<=ones<=WARN_SECS.
- Back-to-back ticks on consecutive cycles are each counted. No tick is lost on a state-transition cycle while in RUN.

Test Plan:
- Reset mid-RUN: preset 12, start, 3 ticks, assert reset low between clock edges -> outputs clear immediately with no clock edge; state=00, digits 00.
- TICKS_PER_SEC=3, preset 10, start, 3 ticks -> digits 09 (ones-borrow path). 27 more ticks -> digits 00, time_up high for exactly one cycle, state=11, expired=1.
- WARN_SECS=5, preset 07, start, ticks -> warn low at 07, 06; high at 05..01; low at 00 and in EXPIRED.
- Pause/resume: preset 05, start, 2 ticks, stop, 10 ticks, start, 1 tick -> digits 05 during pause, 04 after resume tick (partial second kept).
- Simultaneous events: at remaining 01 with counter=2, stop+tick same cycle -> EXPIRED, time_up pulses. In PAUSE, load 3A with start same cycle -> state IDLE, digits 39.
- Ignored requests: start with preset 00 -> stays IDLE. load during RUN -> digits unchanged. start in EXPIRED -> stays EXPIRED. ticks in IDLE -> digits unchanged.
